// File: rtl/ysyx_22050612_rf_pkg.sv
// Shared widths and constants for the register file
// and its busy-bit scoreboard.
package ysyx_22050612_rf_pkg;
    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 64;
    localparam int RF_NR_RD  = 2;
    localparam int RF_ZERO   = 0;
endpackage

// File: rtl/ysyx_22050612_rf_busy_table.sv
// Busy-bit table: tracks registers that have an issued
// but not yet retired writer, plus a running popcount.
module ysyx_22050612_rf_busy_table
    import ysyx_22050612_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int NR_RD      = RF_NR_RD
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wen,
    input  logic [ADDR_WIDTH-1:0]       waddr,
    input  logic                        claim_en,
    input  logic [ADDR_WIDTH-1:0]       claim_addr,
    input  logic [NR_RD*ADDR_WIDTH-1:0] raddr,
    output logic                        claim_ok,
    output logic [NR_RD-1:0]            busy_rd,
    output logic [ADDR_WIDTH:0]         busy_cnt
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(RF_ZERO);

    logic [NREG-1:0]     busy_q, busy_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                set, clr, inc, dec;

    always_comb begin
        claim_ok = claim_en && ((claim_addr == ZERO) || !busy_q[claim_addr]
                   || (wen && (waddr == claim_addr)));
        set = claim_ok && (claim_addr != ZERO);
        clr = wen && (waddr != ZERO);
        inc = set && !busy_q[claim_addr];
        // a retiring write to the same register is overridden by the claim
        dec = clr && busy_q[waddr] && !(set && (claim_addr == waddr));
        busy_d = busy_q;
        if (clr) busy_d[waddr] = 1'b0;
        if (set) busy_d[claim_addr] = 1'b1;
        cnt_d = cnt_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar i = 0; i < NR_RD; i++) begin : g_busy_rd
        assign busy_rd[i] = busy_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
    end

    assign busy_cnt = cnt_q;
endmodule

// File: rtl/ysyx_22050612_rf_scoreboard.sv
// Integer register file with write bypass and a WAW/RAW
// scoreboard for the issue stage.
module ysyx_22050612_rf_scoreboard
    import ysyx_22050612_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int NR_RD      = RF_NR_RD
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wen,
    input  logic [ADDR_WIDTH-1:0]                 waddr,
    input  logic [DATA_WIDTH-1:0]                 wdata,
    input  logic [NR_RD*ADDR_WIDTH-1:0]           raddr,
    output logic [NR_RD*DATA_WIDTH-1:0]           rdata,
    output logic [NR_RD-1:0]                      rbusy,
    input  logic                                  claim_en,
    input  logic [ADDR_WIDTH-1:0]                 claim_addr,
    output logic                                  claim_ok,
    output logic [ADDR_WIDTH:0]                   busy_cnt,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] rf_flat
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(RF_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];
    logic [NR_RD-1:0]      busy_rd;

    ysyx_22050612_rf_busy_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NR_RD      (NR_RD)
    ) u_busy (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (wen),
        .waddr      (waddr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .raddr      (raddr),
        .claim_ok   (claim_ok),
        .busy_rd    (busy_rd),
        .busy_cnt   (busy_cnt)
    );

    always_comb begin
        regs_d = regs_q;
        if (wen && (waddr != ZERO)) regs_d[waddr] = wdata;
    end

    // x0 is never written, so its reset value keeps it hardwired to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NR_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  byp;
        assign ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign byp = wen && (waddr == ra) && (waddr != ZERO);
        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = byp ? wdata : regs_q[ra];
        assign rbusy[i] = busy_rd[i] && !byp;
    end

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign rf_flat[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
endmodule

// File: tb/tb_ysyx_22050612_rf_scoreboard.sv
// Directed and model-checked random stimulus for
// ysyx_22050612_rf_scoreboard.
module tb_ysyx_22050612_rf_scoreboard;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              claim_en;
    logic [AW-1:0]     claim_addr;
    logic              claim_ok;
    logic [AW:0]       busy_cnt;
    logic [32*DW-1:0]  rf_flat;

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] m_regs [32];
    logic          m_busy [32];

    ysyx_22050612_rf_scoreboard dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wen        (wen),
        .waddr      (waddr),
        .wdata      (wdata),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .claim_ok   (claim_ok),
        .busy_cnt   (busy_cnt),
        .rf_flat    (rf_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wen = 0; waddr = '0; wdata = '0;
        claim_en = 0; claim_addr = '0;
    endtask

    function automatic logic [DW-1:0] rd(input int p);
        return rdata[p*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] flat(input int k);
        return rf_flat[k*DW +: DW];
    endfunction

    initial begin
        rst_n = 0; raddr = '0;
        idle();
        #12;
        chk("rst_cnt", DW'(busy_cnt), 0);
        chk("rst_flat_or", DW'(|rf_flat), 0);
        for (int a = 0; a < 32; a++) begin
            raddr = {AW'(a), AW'(a)};
            #1;
            chk("rst_rdata", rd(0) | rd(1), 0);
            chk("rst_rbusy", DW'(rbusy), 0);
        end
        rst_n = 1;
        tick();

        // claim x5 then retire it with a bypassed read
        claim_en = 1; claim_addr = 5; #1;
        chk("claim5_ok", DW'(claim_ok), 1);
        tick(); idle();
        raddr = {AW'(0), AW'(5)}; #1;
        chk("x5_rbusy", DW'(rbusy[0]), 1);
        chk("x5_cnt", DW'(busy_cnt), 1);
        wen = 1; waddr = 5; wdata = 64'hDEAD; #1;
        chk("x5_byp", rd(0), 64'hDEAD);
        chk("x5_byp_rbusy", DW'(rbusy[0]), 0);
        chk("x5_flat_nobyp", flat(5), 0);
        tick(); idle(); #1;
        chk("x5_cnt0", DW'(busy_cnt), 0);
        chk("x5_stored", rd(0), 64'hDEAD);
        chk("x5_flat", flat(5), 64'hDEAD);

        // WAW stall on x7, then claim together with its retirement
        claim_en = 1; claim_addr = 7; tick();
        chk("x7_cnt1", DW'(busy_cnt), 1);
        #1;
        chk("x7_stall", DW'(claim_ok), 0);
        tick();
        chk("x7_stall_cnt", DW'(busy_cnt), 1);
        wen = 1; waddr = 7; wdata = 64'h77; #1;
        chk("x7_wr_claim_ok", DW'(claim_ok), 1);
        tick(); idle();
        raddr = {AW'(7), AW'(0)}; #1;
        chk("x7_cnt_same", DW'(busy_cnt), 1);
        chk("x7_still_busy", DW'(rbusy[1]), 1);
        chk("x7_data", rd(1), 64'h77);
        wen = 1; waddr = 7; wdata = 64'h99; tick(); idle();
        chk("x7_cnt0", DW'(busy_cnt), 0);

        // x0 is hardwired
        wen = 1; waddr = 0; wdata = 64'h1234;
        claim_en = 1; claim_addr = 0; raddr = '0; #1;
        chk("x0_byp", rd(0) | rd(1), 0);
        chk("x0_claim_ok", DW'(claim_ok), 1);
        tick(); idle(); #1;
        chk("x0_read", rd(0), 0);
        chk("x0_cnt", DW'(busy_cnt), 0);
        chk("x0_busy", DW'(rbusy), 0);

        // write to a register that was never claimed
        wen = 1; waddr = 9; wdata = 64'hAB; tick(); idle();
        raddr = {AW'(9), AW'(9)}; #1;
        chk("x9_data", rd(1), 64'hAB);
        chk("x9_busy", DW'(rbusy), 0);
        chk("x9_cnt", DW'(busy_cnt), 0);

        // claims of x1..x3, then a mid-cycle reset
        for (int r = 1; r <= 3; r++) begin
            claim_en = 1; claim_addr = AW'(r); tick();
        end
        idle();
        chk("x123_cnt", DW'(busy_cnt), 3);
        raddr = {AW'(3), AW'(1)};
        #2 rst_n = 0; #1;
        chk("arst_cnt", DW'(busy_cnt), 0);
        chk("arst_rbusy", DW'(rbusy), 0);
        chk("arst_flat", DW'(|rf_flat), 0);
        #2 rst_n = 1;
        tick();
        claim_en = 1; claim_addr = 1; #1;
        chk("post_rst_ok", DW'(claim_ok), 1);
        tick();
        // claim x4 while retiring x1: counter holds
        claim_addr = 4; wen = 1; waddr = 1; wdata = 64'h11; tick(); idle();
        raddr = {AW'(1), AW'(4)}; #1;
        chk("mix_cnt", DW'(busy_cnt), 1);
        chk("mix_busy", DW'(rbusy), 2'b01);

        // random phase against a reference model from a clean reset
        rst_n = 0; #2; rst_n = 1;
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = '0; m_busy[k] = 0;
        end
        tick();
        for (int c = 0; c < 3000; c++) begin
            logic          e_ok;
            logic [DW-1:0] e_rd;
            logic          e_byp;
            int            pop;
            wen = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, 7));
            wdata = {$urandom, $urandom};
            claim_en = 1'($urandom_range(0, 1));
            claim_addr = AW'($urandom_range(0, 7));
            raddr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            #1;
            for (int p = 0; p < NR; p++) begin
                int a;
                a = int'(raddr[p*AW +: AW]);
                e_byp = wen && (int'(waddr) == a) && (a != 0);
                e_rd = e_byp ? wdata : m_regs[a];
                chk("rnd_rdata", rd(p), e_rd);
                chk("rnd_rbusy", DW'(rbusy[p]), DW'(m_busy[a] && !e_byp));
            end
            e_ok = claim_en && (claim_addr == 0 || !m_busy[claim_addr]
                   || (wen && waddr == claim_addr));
            chk("rnd_claim_ok", DW'(claim_ok), DW'(e_ok));
            tick();
            if (wen && waddr != 0) begin
                m_regs[waddr] = wdata;
                m_busy[waddr] = 0;
            end
            if (e_ok && claim_addr != 0) m_busy[claim_addr] = 1;
            pop = 0;
            for (int k = 0; k < 32; k++) pop += int'(m_busy[k]);
            chk("rnd_cnt", DW'(busy_cnt), DW'(pop));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
